load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the ALU in the RISC-V core.
- Takes the ALU result as the effective address and the register-file second read port (rs2) as store data.
- Performs one load or store per request over a variable-latency, ack-based data-memory bus.
- Stalls the core until the access completes, then returns the aligned, sign/zero-extended load data for register writeback.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in REQ without mem_ack before the access aborts with err; valid range 1..65535.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a load/store this cycle.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3: size/signedness.
- req_addr  in  32  effective address (ALU_out).
- req_wdata  in  32  store data (rs2).
- stall  out  1  hold PC and pipeline state.
- done  out  1  one-cycle pulse: access finished; rdata/err valid.
- rdata  out  32  extended load data; 0 for stores.
- err  out  1  misaligned, illegal funct3, or timeout; valid with done.
- mem_req  out  1  bus request, held until ack.
- mem_we  out  1  bus write.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables; 0000 on loads.
- mem_ack  in  1  bus completes access this cycle.
- mem_rdata  in  32  read word, valid with mem_ack.

Behaviour:
- Reset (rst=0, async): state=IDLE; timeout counter=0; latched request=0.
  - All outputs 0: stall, done, rdata, err, mem_req, mem_we, mem_addr, mem_wdata, mem_be.
  - Reset during REQ aborts the access; mem_req drops immediately.
- funct3 encodings:
  - 000 byte, signed load.
  - 001 half, signed load.
  - 010 word.
  - 100 byte, unsigned load.
  - 101 half, unsigned load.
  - Illegal: 011, 110, 111; 100 and 101 with req_we=1.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- stall = (state==IDLE && req_valid) || state==REQ. Combinational, so the core freezes in the request cycle.
- Request inputs are sampled only in IDLE. req_valid in REQ or RESP is ignored; the core holds the same instruction there.
- IDLE:
  - req_valid, legal and aligned: latch we, funct3, addr[1:0], lane data, be → REQ.
  - req_valid, illegal or misaligned: → RESP with err=1, rdata=0; no bus activity.
- REQ:
  - mem_req=1; mem_we/mem_addr/mem_wdata/mem_be are driven from latched registers and stay stable until ack.
  - Counter increments each cycle without ack.
  - mem_ack: capture and extend mem_rdata (loads) or set rdata=0 (stores), err=0 → RESP.
  - Counter reaches TIMEOUT_CYCLES without ack: err=1, rdata=0 → RESP.
  - Ack in the same cycle as timeout: ack wins, err=0.
- RESP: done=1 and stall=0 for exactly one cycle → IDLE. Counter clears. rdata and err are registered and hold until the next RESP.
- mem_ack outside REQ is ignored.
- Store lane rules:
  - SB: be=0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - SH: be=0011 (addr[1]=0) or 1100 (addr[1]=1); wdata={2{wdata[15:0]}}.
  - SW: be=1111; wdata as-is.
- Load extraction: byte lane = mem_rdata[8*addr[1:0]+:8]; half lane = mem_rdata[16*addr[1]+:16]. Sign- or zero-extend per funct3.
- Latency: ack after N cycles in REQ gives stall for 1+N cycles; done is N+1 cycles after the request cycle. Illegal or misaligned requests stall for 1 cycle, done next cycle.

Test Plan:
- Reset mid-access: enter REQ, drop rst → mem_req=0, stall=0, all outputs 0 immediately; after release, idle until req_valid.
- LB at 0x1003, mem_rdata=0x80FF_1234, ack after 2 cycles → mem_addr=0x1000, mem_be=0000, stall 3 cycles, done with rdata=0xFFFF_FF80, err=0. Same with LBU → rdata=0x0000_0080.
- SH at 0x2002, rs2=0xDEAD_BEEF, ack after 1 cycle → mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, done with rdata=0, err=0.
- LW at 0x3001 → no mem_req; done next cycle with err=1, rdata=0. SW with funct3=100 → same result.
- LW at 0x4000, TIMEOUT_CYCLES=4, no ack → mem_req high exactly 4 cycles, then done with err=1, rdata=0.
- Ack on the timeout cycle, mem_rdata=0x1234_5678 → rdata=0x1234_5678, err=0. Back-to-back request held through RESP → exactly one bus access per request.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit on an ack-based data-memory bus
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;

    logic        req_illegal;
    logic        req_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_lane_wdata;

    always_comb begin
        req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                req_be         = 4'b0001 << req_addr[1:0];
                req_lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_misaligned = req_addr[0];
                req_be         = req_addr[1] ? 4'b1100 : 4'b0011;
                req_lane_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                req_misaligned = (req_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Stall is combinational so the core freezes in the very cycle it issues the request.
    assign stall = ((state == IDLE) && req_valid) || (state == REQ);

    function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] result;
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {off[1], 4'b0000};
        case (funct3)
            3'b000:  result = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  result = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b100:  result = {24'd0, byte_sh[7:0]};
            3'b101:  result = {16'd0, half_sh[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_off    <= 2'd0;
            done       <= 1'b0;
            rdata      <= 32'd0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (req_valid) begin
                        if (req_illegal || req_misaligned) begin
                            err   <= 1'b1;
                            rdata <= 32'd0;
                            done  <= 1'b1;
                            state <= RESP;
                        end else begin
                            lat_we     <= req_we;
                            lat_funct3 <= req_funct3;
                            lat_off    <= req_addr[1:0];
                            mem_req    <= 1'b1;
                            mem_we     <= req_we;
                            mem_addr   <= {req_addr[31:2], 2'b00};
                            mem_wdata  <= req_we ? req_lane_wdata : 32'd0;
                            mem_be     <= req_we ? req_be : 4'b0000;
                            cnt        <= 16'd0;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack landing on the final timeout cycle still completes normally.
                    if (mem_ack) begin
                        rdata   <= lat_we ? 32'd0 : extend_load(lat_funct3, lat_off, mem_rdata);
                        err     <= 1'b0;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                        state   <= RESP;
                    end else if (cnt == TIMEOUT_LAST) begin
                        rdata   <= 32'd0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    done  <= 1'b0;
                    cnt   <= 16'd0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and random checks of load_store_unit against a behavioural model
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input int f3);
        return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    endfunction

    function automatic bit model_bad(input bit we, input int f3, input int unsigned addr);
        bit illegal;
        illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
        return illegal || ((addr % size_bytes(f3)) != 0);
    endfunction

    function automatic int unsigned model_be(input bit we, input int f3, input int unsigned addr);
        if (!we) return 0;
        return ((1 << size_bytes(f3)) - 1) << (addr % 4);
    endfunction

    function automatic int unsigned model_wdata(input bit we, input int f3, input int unsigned wd);
        if (!we) return 0;
        case (size_bytes(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic int unsigned model_load(input int f3, input int unsigned addr, input int unsigned word);
        int unsigned n;
        int unsigned v;
        n = size_bytes(f3);
        if (n == 4) return word;
        v = (word >> (8 * (addr % 4))) & ((1 << (8 * n)) - 1);
        if (f3 < 4 && v >= (1 << (8 * n - 1))) v = v - (1 << (8 * n));
        return v;
    endfunction

    // Issues one request at a negedge in IDLE and follows it to the cycle after done.
    task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] word);
        bit          bad;
        bit          got;
        bit          exp_err;
        logic [31:0] exp_rdata;
        bad = model_bad(we, int'(f3), addr);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        #1;
        check("stall_request_cycle", 32'(stall), 32'd1);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = $urandom;
        if (bad) begin
            exp_err   = 1'b1;
            exp_rdata = 32'd0;
            check("bad_no_mem_req", 32'(mem_req), 32'd0);
        end else begin
            for (int n = 1; n <= TO; n++) begin
                check("req_mem_req", 32'(mem_req), 32'd1);
                check("req_stall", 32'(stall), 32'd1);
                check("req_mem_we", 32'(mem_we), 32'(we));
                check("req_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check("req_mem_be", 32'(mem_be), model_be(we, int'(f3), addr));
                check("req_mem_wdata", mem_wdata, model_wdata(we, int'(f3), wd));
                got = (n == ack_at);
                mem_ack   = got;
                mem_rdata = got ? word : $urandom;
                @(posedge clk); @(negedge clk);
                mem_ack = 1'b0;
                if (got) break;
            end
            exp_err   = !(ack_at >= 1 && ack_at <= TO);
            exp_rdata = (exp_err || we) ? 32'd0 : model_load(int'(f3), addr, word);
        end
        check("resp_done", 32'(done), 32'd1);
        check("resp_err", 32'(err), 32'(exp_err));
        check("resp_rdata", rdata, exp_rdata);
        check("resp_stall", 32'(stall), 32'd0);
        check("resp_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); @(negedge clk);
        check("done_single_pulse", 32'(done), 32'd0);
        check("rdata_held", rdata, exp_rdata);
        check("err_held", 32'(err), 32'(exp_err));
    endtask

    initial begin
        int acc;
        int dones;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        access(1'b0, 3'b000, 32'h0000_1003, 32'd0, 2, 32'h80FF_1234);
        access(1'b0, 3'b100, 32'h0000_1003, 32'd0, 2, 32'h80FF_1234);
        access(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 1, 32'd0);
        access(1'b0, 3'b010, 32'h0000_3001, 32'd0, 1, 32'd0);
        access(1'b1, 3'b100, 32'h0000_3000, 32'h1111_2222, 1, 32'd0);
        access(1'b0, 3'b010, 32'h0000_4000, 32'd0, 0, 32'd0);
        access(1'b0, 3'b010, 32'h0000_4000, 32'd0, TO, 32'h1234_5678);
        access(1'b0, 3'b001, 32'h0000_5002, 32'd0, 3, 32'hF00D_8001);

        // Leave nonzero rdata, then reset in the middle of a bus access.
        access(1'b0, 3'b000, 32'h0000_1003, 32'd0, 1, 32'h80FF_1234);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_6000; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check("mid_mem_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_wdata", mem_wdata, 32'd0);
        check("mid_rst_mem_be", 32'(mem_be), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle_mem_req", 32'(mem_req), 32'd0);
            check("post_rst_idle_done", 32'(done), 32'd0);
            check("post_rst_idle_stall", 32'(stall), 32'd0);
        end
        mem_ack = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom % 2) a[1:0] = 2'b00;
            access(1'($urandom % 2), 3'($urandom % 8), a, $urandom, int'($urandom % 6), $urandom);
        end

        // Core holds req_valid through RESP: each request must produce exactly one bus access.
        acc = 0; dones = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_7000;
        for (int i = 0; i < 12; i++) begin
            acc   += int'(mem_req);
            dones += int'(done);
            mem_ack   = mem_req;
            mem_rdata = $urandom;
            @(posedge clk); @(negedge clk);
        end
        req_valid = 1'b0; mem_ack = 1'b0;
        check("b2b_accesses", 32'(acc), 32'd4);
        check("b2b_dones", 32'(dones), 32'd4);
        @(negedge clk);
        check("b2b_final_idle", 32'(stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
